// File: rtl/output_arbiter.sv
// Wormhole round-robin arbiter sharing one router output port among N_INPUTS channels.
// Define OUTPUT_ARBITER_PERF_CNT_EN to add the pkt_count / stall_count performance counters.
module output_arbiter #(
  parameter int N_INPUTS = 4,
  parameter int FLIT_W   = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_INPUTS-1:0]          in_valid,
  output logic [N_INPUTS-1:0]          in_ready,
  input  logic [N_INPUTS*FLIT_W-1:0]   in_flit,
  input  logic [N_INPUTS-1:0]          in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FLIT_W-1:0]            out_flit,
  output logic                         out_last,
  output logic [N_INPUTS-1:0]          grant,
  output logic                         locked
`ifdef OUTPUT_ARBITER_PERF_CNT_EN
  ,
  output logic [31:0]                  pkt_count,
  output logic [31:0]                  stall_count
`endif
);

  localparam int PTR_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_r;
  logic [PTR_W-1:0] owner_r;
  logic [PTR_W-1:0] rr_ptr_r;

  logic             win_found_s;
  logic [PTR_W-1:0] win_idx_s;
  logic [PTR_W:0]   scan_sum_s;
  logic [PTR_W:0]   scan_idx_s;
  logic             scan_hit_s;
  logic [PTR_W-1:0] cur_idx_s;
  logic             cur_active_s;
  logic             handshake_s;
  logic [PTR_W-1:0] next_ptr_s;
  logic             sel_s;

  // Round-robin scan; walking offsets downward lets the smallest offset from rr_ptr win.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_sum_s  = '0;
    scan_idx_s  = '0;
    scan_hit_s  = 1'b0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      scan_sum_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      if (scan_sum_s >= (PTR_W+1)'(N_INPUTS)) begin
        scan_idx_s = scan_sum_s - (PTR_W+1)'(N_INPUTS);
      end else begin
        scan_idx_s = scan_sum_s;
      end
      scan_hit_s  = in_valid[scan_idx_s[PTR_W-1:0]];
      win_found_s = win_found_s | scan_hit_s;
      win_idx_s   = scan_hit_s ? scan_idx_s[PTR_W-1:0] : win_idx_s;
    end
  end

  // Select the current source (winner or locked owner) and forward it with zero latency.
  always_comb begin
    cur_idx_s    = win_idx_s;
    cur_active_s = win_found_s;
    case (state_r)
      IDLE: begin
        cur_idx_s    = win_idx_s;
        cur_active_s = win_found_s;
      end
      LOCKED: begin
        cur_idx_s    = owner_r;
        cur_active_s = 1'b1;
      end
      default: begin
        cur_idx_s    = '0;
        cur_active_s = 1'b0;
      end
    endcase

    grant    = '0;
    out_flit = '0;
    sel_s    = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      sel_s    = cur_active_s && (PTR_W'(i) == cur_idx_s);
      grant[i] = sel_s;
      out_flit = out_flit | (in_flit[i*FLIT_W +: FLIT_W] & {FLIT_W{sel_s}});
    end

    out_valid   = |(grant & in_valid);
    out_last    = |(grant & in_last);
    in_ready    = grant & {N_INPUTS{out_ready}};
    handshake_s = out_valid & out_ready;
    next_ptr_s  = (cur_idx_s == PTR_W'(N_INPUTS - 1)) ? '0 : cur_idx_s + PTR_W'(1);
    locked      = (state_r == LOCKED);
  end

  // Arbitration FSM: a completed last flit releases the port, any other visible flit holds it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      owner_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      case (state_r)
        IDLE, LOCKED: begin
          if (handshake_s && out_last) begin
            state_r  <= IDLE;
            rr_ptr_r <= next_ptr_s;
          end else if (out_valid) begin
            state_r <= LOCKED;
            owner_r <= cur_idx_s;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef OUTPUT_ARBITER_PERF_CNT_EN
  // Completed packets and backpressured cycles; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count   <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (handshake_s && out_last) begin
        pkt_count <= pkt_count + 32'd1;
      end else begin
        pkt_count <= pkt_count;
      end
      if (out_valid && !out_ready) begin
        stall_count <= stall_count + 32'd1;
      end else begin
        stall_count <= stall_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Directed self-checking bench for output_arbiter (N_INPUTS = 4, FLIT_W = 64).
module tb_output_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [N*W-1:0]   in_flit;
  logic [N-1:0]     in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_flit;
  logic             out_last;
  logic [N-1:0]     grant;
  logic             locked;
`ifdef OUTPUT_ARBITER_PERF_CNT_EN
  logic [31:0]      pkt_count;
  logic [31:0]      stall_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] base [N] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};

  output_arbiter #(.N_INPUTS(N), .FLIT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_flit    (in_flit),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_flit   (out_flit),
    .out_last   (out_last),
    .grant      (grant),
    .locked     (locked)
`ifdef OUTPUT_ARBITER_PERF_CNT_EN
    ,
    .pkt_count  (pkt_count),
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_flits();
    for (int i = 0; i < N; i++) in_flit[i*W +: W] = base[i];
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_last   = 4'b0000;
    out_ready = 1'b0;
    load_flits();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp %b", grant, 4'b0000); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp %b", in_ready, 4'b0000); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      exp_g = 4'(1 << (c % 4));
      #1;
      checks++;
      if (grant !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", c, grant, exp_g); end
      checks++;
      if (out_flit !== base[c % 4]) begin errors++; $display("FAIL rr_flit[%0d] got %h exp %h", c, out_flit, base[c % 4]); end
      checks++;
      if (in_ready !== exp_g || out_valid !== 1'b1) begin
        errors++; $display("FAIL rr_ready[%0d] got %b/%b exp %b/1", c, in_ready, out_valid, exp_g);
      end
      tick();
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_wormhole();
    logic [W-1:0] pkt [3] = '{64'h0000_0000_0000_0C01, 64'h0000_0000_0000_0C02, 64'h0000_0000_0000_0C03};
    do_reset();
    out_ready = 1'b1;
    // single flit from input 1 moves rr_ptr to 2
    in_valid = 4'b0010;
    in_last  = 4'b1111;
    tick();
    in_valid = 4'b0101;
    in_last  = 4'b1011;
    for (int f = 0; f < 3; f++) begin
      in_flit[2*W +: W] = pkt[f];
      in_last[2]        = (f == 2);
      #1;
      checks++;
      if (grant !== 4'b0100 || in_ready !== 4'b0100) begin
        errors++; $display("FAIL worm_grant[%0d] got %b/%b exp 0100/0100", f, grant, in_ready);
      end
      checks++;
      if (out_flit !== pkt[f] || out_last !== (f == 2)) begin
        errors++; $display("FAIL worm_flit[%0d] got %h/%b exp %h/%b", f, out_flit, out_last, pkt[f], (f == 2));
      end
      if (f > 0) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL worm_locked[%0d] got %b exp 1", f, locked); end
      end
      tick();
    end
    in_valid = 4'b1101;
    #1;
    checks++;
    if (grant !== 4'b1000 || out_flit !== base[3]) begin
      errors++; $display("FAIL worm_next3 got %b/%h exp 1000/%h", grant, out_flit, base[3]);
    end
    tick();
    in_valid = 4'b0101;
    #1;
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL worm_next0 got %b exp 0001", grant); end
    tick();
    in_valid = 4'b0000;
    load_flits();
    tick();
  endtask

  task automatic test_stall_lock();
    do_reset();
    in_last   = 4'b1111;
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0010 || out_valid !== 1'b1 || locked !== 1'b0 || in_ready !== 4'b0000) begin
      errors++; $display("FAIL stall_first got g=%b v=%b l=%b r=%b exp 0010/1/0/0000", grant, out_valid, locked, in_ready);
    end
    tick();
    in_valid = 4'b0011;
    #1;
    checks++;
    if (grant !== 4'b0010 || out_flit !== base[1] || locked !== 1'b1) begin
      errors++; $display("FAIL stall_hold got g=%b f=%h l=%b exp 0010/%h/1", grant, out_flit, locked, base[1]);
    end
    tick();
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010 || out_flit !== base[1] || locked !== 1'b1) begin
      errors++; $display("FAIL stall_release got r=%b f=%h l=%b exp 0010/%h/1", in_ready, out_flit, locked, base[1]);
    end
    tick();
    #1;
    checks++;
    if (grant !== 4'b0001 || locked !== 1'b0) begin
      errors++; $display("FAIL stall_after got g=%b l=%b exp 0001/0", grant, locked);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_gap();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'b0010;
    in_last   = 4'b0000;
    #1;
    checks++;
    if (grant !== 4'b0010 || out_last !== 1'b0) begin errors++; $display("FAIL gap_start got %b/%b exp 0010/0", grant, out_last); end
    tick();
    in_valid = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || locked !== 1'b1 || grant !== 4'b0010 || in_ready[0] !== 1'b0) begin
        errors++; $display("FAIL gap_hole[%0d] got v=%b l=%b g=%b r=%b exp 0/1/0010/xxx0", c, out_valid, locked, grant, in_ready);
      end
      tick();
    end
    in_valid = 4'b0011;
    in_last  = 4'b0010;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_flit !== base[1] || grant !== 4'b0010) begin
      errors++; $display("FAIL gap_resume got v=%b f=%h g=%b exp 1/%h/0010", out_valid, out_flit, grant, base[1]);
    end
    tick();
    #1;
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL gap_end got %b exp 0", locked); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'b1000;
    in_last   = 4'b0000;
    tick();
    in_valid = 4'b1001;
    #1;
    checks++;
    if (locked !== 1'b1 || grant !== 4'b1000) begin errors++; $display("FAIL rstmid_lock got %b/%b exp 1/1000", locked, grant); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (locked !== 1'b0 || grant !== 4'b0001 || out_flit !== base[0]) begin
      errors++; $display("FAIL rstmid_after got l=%b g=%b f=%h exp 0/0001/%h", locked, grant, out_flit, base[0]);
    end
    in_valid = 4'b0000;
    tick();
  endtask

`ifdef OUTPUT_ARBITER_PERF_CNT_EN
  task automatic test_perf();
    logic [7:0] rdy_pat = 8'b1110_0101;
    do_reset();
    #1;
    checks++;
    if (pkt_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", pkt_count, stall_count);
    end
    in_valid = 4'b0001;
    in_last  = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      out_ready = rdy_pat[c];
      tick();
    end
    in_valid = 4'b0000;
    #1;
    checks++;
    if (pkt_count !== 32'd5 || stall_count !== 32'd3) begin
      errors++; $display("FAIL perf_counts got %0d/%0d exp 5/3", pkt_count, stall_count);
    end
    tick();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_last   = 4'b0000;
    out_ready = 1'b0;
    in_flit   = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_wormhole();
    test_stall_lock();
    test_gap();
    test_reset_mid_packet();
`ifdef OUTPUT_ARBITER_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
# output_arbiter

Wormhole round-robin arbiter that shares one router output port among `N_INPUTS` input channels. Each input presents a routed flit stream already steered to this port; the arbiter picks one input, then locks onto it until that packet's last flit is accepted, so flits of different packets never interleave on the output link. It sits between the input channels' routed outputs and the output link/buffer of one router port.

## Interface
- `N_INPUTS`, default 4: number of competing input channels; legal range 2..16.
- `FLIT_W`, default 64: width of one flit payload in bits, including the tag.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input N_INPUTS: per-input flit valid.
- `in_ready` output N_INPUTS: per-input flit accepted.
- `in_flit` input N_INPUTS*FLIT_W: flits; input i occupies bits [i*FLIT_W +: FLIT_W].
- `in_last` input N_INPUTS: flit is the final flit of its packet (START_AND_END or TAIL).
- `out_valid` output 1: output flit valid.
- `out_ready` input 1: downstream accepts the flit.
- `out_flit` output FLIT_W: flit of the granted input.
- `out_last` output 1: `in_last` of the granted input.
- `grant` output N_INPUTS: one-hot current owner; all zero when no input is granted.
- `locked` output 1: high while a packet holds the port (state LOCKED).

## Operation
- State machine: IDLE and LOCKED. Registers: `state`, `owner` (clog2 N_INPUTS bits), `rr_ptr` (clog2 N_INPUTS bits).
- IDLE:
  - Winner is the first asserted `in_valid` scanning upward from `rr_ptr`, wrapping modulo N_INPUTS.
  - `grant` is the winner's one-hot; `out_*` forward the winner combinationally.
  - If no input is valid, `grant` is 0 and `out_valid` is 0.
- LOCKED: `grant` = one-hot(`owner`); `out_*` forward input `owner` regardless of the other inputs.
- `in_ready[i]` = `grant[i] && out_ready`. All other inputs see ready low.
- Handshake = `out_valid && out_ready`.
- Transitions at a clock edge with a granted input g:
  - Handshake with `out_last` = 1: state becomes IDLE, `rr_ptr` becomes (g+1) mod N_INPUTS. This covers single-flit packets completing in IDLE.
  - Otherwise, if `out_valid` is high (no handshake, or a non-last handshake): state becomes LOCKED and `owner` becomes g.
  - When `owner` is the largest input index, (g+1) mod N_INPUTS wraps `rr_ptr` to 0.
- The stall lock is required so the output obeys the stream contract: once `out_valid` is asserted, payload and `out_valid` stay stable until the handshake, even if a higher-priority input becomes valid.
- In LOCKED, if the owner drops `in_valid` mid-packet, the arbiter stays LOCKED and `out_valid` goes low. There is no timeout.
- Fairness: with every input continuously valid, each input is granted exactly once per N_INPUTS packets.

## Timing
- Zero-cycle forwarding: `in_valid`→`out_valid`, `in_flit`→`out_flit` and `out_ready`→`in_ready` are combinational. There are no pipeline registers on the data path.
- Full throughput: one flit per cycle, including back-to-back packets from different inputs with no bubble between them.
- Values after reset: `state` = IDLE, `owner` = 0, `rr_ptr` = 0. Outputs are therefore `locked` = 0 and `grant`, `out_valid`, `in_ready` all 0 until some `in_valid` rises.
- Reset mid-packet abandons the lock. The next cycle arbitrates from input 0; the partial packet is not completed.

## Configuration
- `OUTPUT_ARBITER_PERF_CNT_EN` defined adds two outputs:
  - `pkt_count` output 32: increments on each handshake with `out_last` = 1.
  - `stall_count` output 32: increments each cycle with `out_valid && !out_ready`.
  - Both counters wrap at 2^32 and reset to 0.
- Without the macro: neither port nor register exists, and behaviour is otherwise identical.

## Test plan
- Reset with all inputs valid, `out_ready` = 1, N_INPUTS = 4, single-flit packets → grants in order 0,1,2,3,0, one flit per cycle.
- Input 2 sends a 3-flit packet while input 0 is valid throughout → `grant` = 4'b0100 for 3 consecutive handshakes, then input 3 (if valid) or input 0 next. Input 0 never sees `in_ready` mid-packet.
- In IDLE with `rr_ptr` = 0, input 1 valid, `out_ready` = 0; next cycle input 0 also becomes valid → `out_flit` stays input 1's value and `locked` = 1 until the handshake.
- Owner deasserts `in_valid` for 2 cycles mid-packet → `out_valid` = 0 and `locked` = 1 during the gap; the packet resumes from the same input.
- Assert `rst_n` = 0 for one cycle during a LOCKED packet from input 3 → next cycle `locked` = 0 and `rr_ptr` = 0, and input 0 wins if valid.
- With `OUTPUT_ARBITER_PERF_CNT_EN` defined: 5 packets with 3 stall cycles → `pkt_count` = 5, `stall_count` = 3.
